// File: rtl/spi_flash_resp_pkg.sv
// Shared opcodes, FSM state encoding and default ID for the SPI flash responder.
package spi_flash_resp_pkg;

    localparam logic [7:0]  CMD_READ         = 8'h03;
    localparam logic [7:0]  CMD_RDID         = 8'h9F;
    localparam logic [23:0] JEDEC_ID_DEFAULT = 24'hEF4018;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_resp_edge_sync.sv
// Brings SCK, CS and MOSI into the sys_clk domain and derives one-cycle SCK edge pulses.
module spi_edge_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [2:0] sck_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    // Two-flop synchronisers; CS resets to deasserted so busy starts low.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sck_q  <= 3'b000;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sck_rise  =  sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] &  sck_q[2];
    assign cs_n_sync = cs_q[1];
    assign mosi_sync = mosi_q[1];

endmodule

// File: rtl/spi_flash_resp.sv
// Mode-0 SPI flash responder answering READ and READ_ID from a byte-wide memory port.
//
// state  | meaning
// IDLE   | waiting for CS (only after CS has been seen high since reset)
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in the 24-bit read address
// DATA   | streaming memory bytes out on MISO, prefetching the next byte
// ID     | streaming the 3 JEDEC ID bytes, then zeros
// IGNORE | unsupported opcode, MISO held low until CS rises
module spi_flash_resp
    import spi_flash_resp_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter int          CS_IDX   = 0,
    parameter logic [23:0] JEDEC_ID = JEDEC_ID_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_flash_clk,
    input  logic [1:0]        spi_flash_cs,
    input  logic              spi_flash_mosi,
    output logic              spi_flash_miso,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic sck_rise, sck_fall, cs_n_sync, mosi_s;

    spi_edge_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .sck       (spi_flash_clk),
        .cs_n      (spi_flash_cs[CS_IDX]),
        .mosi      (spi_flash_mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_n_sync (cs_n_sync),
        .mosi_sync (mosi_s)
    );

    state_t             state, state_nxt;
    logic [4:0]         bit_cnt, bit_cnt_nxt;
    logic [6:0]         cmd_sh, cmd_nxt;
    logic [22:0]        addr_sh, addr_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [7:0]         tx_shift, tx_nxt;
    logic               miso_nxt, mem_req_nxt;
    logic               load_pend, load_nxt;
    logic [1:0]         id_idx, id_nxt;
    logic               armed, armed_nxt;
    logic [1:0]         sync_warm;
    logic [7:0]         cmd_word;
    logic [23:0]        addr_word;
    logic [7:0]         id_byte;

    // The CS synchroniser holds its reset value for two cycles; arming only
    // after it has settled keeps a CS held low through reset from starting a command.
    assign cmd_word  = {cmd_sh, mosi_s};
    assign addr_word = {addr_sh, mosi_s};
    assign busy      = ~cs_n_sync;

    logic unused_bits;
    assign unused_bits = ^{spi_flash_cs, addr_word};

    // Next ID byte to present once the current one has been shifted out.
    always_comb begin
        case (id_idx)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    // Next-state and datapath decode.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        cmd_nxt      = cmd_sh;
        addr_nxt     = addr_sh;
        mem_addr_nxt = mem_addr;
        tx_nxt       = tx_shift;
        miso_nxt     = spi_flash_miso;
        mem_req_nxt  = 1'b0;
        load_nxt     = 1'b0;
        id_nxt       = id_idx;
        armed_nxt    = armed;

        if (cs_n_sync) begin
            state_nxt   = IDLE;
            miso_nxt    = 1'b0;
            bit_cnt_nxt = 5'd0;
            if (sync_warm[1]) begin
                armed_nxt = 1'b1;
            end
        end else begin
            load_nxt = mem_req;
            case (state)
                IDLE: begin
                    miso_nxt = 1'b0;
                    if (armed) begin
                        state_nxt   = CMD;
                        bit_cnt_nxt = 5'd0;
                    end
                end
                CMD: begin
                    miso_nxt = 1'b0;
                    if (sck_rise) begin
                        cmd_nxt     = cmd_word[6:0];
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = 5'd0;
                            if (cmd_word == CMD_READ) begin
                                state_nxt = ADDR;
                            end else if (cmd_word == CMD_RDID) begin
                                state_nxt = ID;
                                tx_nxt    = JEDEC_ID[23:16];
                                id_nxt    = 2'd1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    miso_nxt = 1'b0;
                    if (sck_rise) begin
                        addr_nxt    = addr_word[22:0];
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt_nxt  = 5'd0;
                            mem_req_nxt  = 1'b1;
                            mem_addr_nxt = addr_word[ADDR_W-1:0];
                            state_nxt    = DATA;
                        end
                    end
                end
                DATA, ID: begin
                    if (sck_fall) begin
                        miso_nxt = tx_shift[7];
                        tx_nxt   = {tx_shift[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt[2:0] == 3'd7) begin
                            if (state == DATA) begin
                                mem_req_nxt  = 1'b1;
                                mem_addr_nxt = mem_addr + ADDR_W'(1);
                            end else begin
                                tx_nxt = id_byte;
                                if (id_idx != 2'd3) begin
                                    id_nxt = id_idx + 2'd1;
                                end
                            end
                        end
                    end
                    // Returned memory byte wins over a coincident fall, which then drives its MSB.
                    if (state == DATA && load_pend) begin
                        tx_nxt = mem_rdata;
                        if (sck_fall) begin
                            miso_nxt = mem_rdata[7];
                            tx_nxt   = {mem_rdata[6:0], 1'b0};
                        end
                    end
                end
                IGNORE: begin
                    miso_nxt = 1'b0;
                end
                default: begin
                    state_nxt = IDLE;
                    miso_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= IDLE;
            bit_cnt        <= 5'd0;
            cmd_sh         <= 7'd0;
            addr_sh        <= 23'd0;
            mem_addr       <= '0;
            tx_shift       <= 8'd0;
            spi_flash_miso <= 1'b0;
            mem_req        <= 1'b0;
            load_pend      <= 1'b0;
            id_idx         <= 2'd0;
            armed          <= 1'b0;
            sync_warm      <= 2'b00;
        end else begin
            state          <= state_nxt;
            bit_cnt        <= bit_cnt_nxt;
            cmd_sh         <= cmd_nxt;
            addr_sh        <= addr_nxt;
            mem_addr       <= mem_addr_nxt;
            tx_shift       <= tx_nxt;
            spi_flash_miso <= miso_nxt;
            mem_req        <= mem_req_nxt;
            load_pend      <= load_nxt;
            id_idx         <= id_nxt;
            armed          <= armed_nxt;
            sync_warm      <= {sync_warm[0], 1'b1};
        end
    end

endmodule

// File: doc/spi_flash_resp.md
Name: spi_flash_resp

Overview:
SPI flash responder: the device end of the spi_flash_* interface driven by the SoC's SPI master. It decodes mode-0 SPI transactions and answers READ (0x03) and READ_ID (0x9F) from a byte-wide memory port. It is used in the FPGA/bench platform as the boot-flash model behind one chip select. It runs entirely in the system clock domain and oversamples SCK, CS and MOSI.

Parameters:
ADDR_W, 24, memory byte-address width; the received 24-bit address is truncated to ADDR_W bits, so higher address bits alias.
CS_IDX, 0, index of the spi_flash_cs bit this responder answers.
JEDEC_ID, 24'hEF4018, 3-byte ID returned MSB byte first by READ_ID.

Ports:
sys_clk  input  1  system clock; must run at least 8x spi_flash_clk.
sys_rst  input  1  synchronous reset, active-high.
spi_flash_clk  input  1  SPI SCK from master, mode 0.
spi_flash_cs  input  2  active-low chip selects; only bit CS_IDX is used.
spi_flash_mosi  input  1  master-out data.
spi_flash_miso  output  1  responder-out data.
mem_req  output  1  one-cycle memory read strobe.
mem_addr  output  ADDR_W  memory byte address; valid while mem_req is high.
mem_rdata  input  8  read data, valid exactly 1 sys_clk after mem_req.
busy  output  1  high while the selected CS is asserted (synchronised view).

Behaviour:
- Reset values: spi_flash_miso=0, mem_req=0, mem_addr=0, busy=0; state=IDLE; all counters and shift registers are 0.
- Synchronisation: SCK, CS[CS_IDX] and MOSI each pass through a 2-flop synchroniser. A third SCK flop gives rise and fall pulses, each one cycle wide.
- MOSI is sampled on the synchronised SCK rise. MISO updates on the synchronised SCK fall. Bits are MSB first.
- CS deasserted (synchronised high) in any state: go to IDLE on the next cycle, set MISO=0, clear the bit counter, drop any pending load. This is also the mid-transfer abort.
- States:
  - IDLE: CS asserted -> CMD, with bit_cnt=0.
  - CMD: shift 8 bits. On the 8th rise: 0x03 -> ADDR; 0x9F -> ID (preload the shift register with JEDEC_ID[23:16]); any other value -> IGNORE.
  - ADDR: shift 24 bits into addr. On the 24th rise, pulse mem_req with mem_addr=addr[ADDR_W-1:0]. On the next cycle, load mem_rdata into tx_shift, then enter DATA.
  - DATA: on each fall, MISO=tx_shift[7] and tx_shift shifts left. The first fall after entry drives bit 7 of byte 0. On the rise of bit 0 of the current byte, pulse mem_req with addr+1 (wraps modulo 2^ADDR_W) and load the returned byte for the next fall. The read is unbounded until CS rises.
  - ID: same shifting as DATA. Source bytes are JEDEC_ID[23:16], [15:8], [7:0]; after the third byte MISO drives 0.
  - IGNORE: MISO=0; stay until CS rises.
- MISO is 0 in IDLE, CMD and ADDR.
- SCK edges seen in IDLE are ignored.
- A load and a fall occurring on the same cycle: the load has priority for the tx_shift write, and that fall drives bit 7 of the newly loaded byte.
- Timing constraint: each SCK half-period must be at least 4 sys_clk. This covers 2 cycles of sync plus the 1-cycle memory latency.
- busy is the synchronised CS, inverted.

Decomposition:
- Shared package: command opcode constants CMD_READ=8'h03 and CMD_RDID=8'h9F, the state encoding (IDLE, CMD, ADDR, DATA, ID, IGNORE), and the default JEDEC_ID.
- One natural sub-module: spi_edge_sync. It holds the 2-flop synchronisers for SCK, CS and MOSI plus the rise/fall pulse generation.

Test Plan:
- READ at 0x000010, memory holding byte i = i[7:0], SCK = sys_clk/8, 4 data bytes clocked -> MISO returns 0x10,0x11,0x12,0x13; mem_req pulses exactly 5 times (4 used bytes + 1 prefetch).
- READ_ID, 5 bytes clocked -> EF,40,18,00,00.
- ADDR_W=8, READ at 0x0000FE, 3 bytes -> data from 0xFE, 0xFF, 0x00 (wrap); mem_addr never exceeds 0xFF.
- Command 0xAB plus 16 SCKs -> MISO stays 0 throughout, no mem_req, busy=1 until CS rises.
- CS deasserted after 12 address bits, then a fresh READ at 0x000020 -> first byte is mem[0x20]; no state leaks from the aborted transfer.
- sys_rst asserted mid-DATA while CS stays low -> outputs return to reset values next cycle; the responder stays in IDLE-equivalent behaviour until CS toggles high then low; spi_flash_cs[1] activity is ignored when CS_IDX=0.
